fp_norm_pack: RTL and testbench
===============================

Name: fp_norm_pack

Overview:
Post-adder stage of the single-precision add/sub datapath. Consumes the raw 25-bit mantissa sum, result sign and biased exponent produced by the alignment/add stage. Normalizes iteratively (right by 1 on carry, left until hidden bit set), rounds to nearest-even and packs an IEEE-754 single for display/readout. Valid/ready handshake on both sides; one operation in flight.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, fraction field width (raw mantissa input is MAN_W+2 bits)
BIAS, 127, exponent bias (informational; used for overflow constant 2**EXP_W-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream result available
in_ready  out  1  block can accept (high only in IDLE)
in_sign  in  1  result sign
in_exp  in  EXP_W  biased exponent of larger operand
in_mant  in  MAN_W+2  raw sum; bit MAN_W+1 = carry, bit MAN_W = hidden-one position
out_valid  out  1  packed result valid
out_ready  in  1  downstream accepts
out_result  out  32  {sign, exp, fraction}
out_flags  out  3  {overflow, underflow, zero}
state_leds  out  4  one-hot state indicator for board LEDs

Behaviour:
- Reset (reset=0, async): state IDLE, in_ready=1, out_valid=0, out_result=0, out_flags=0, state_leds=4'b0001. Reset mid-operation abandons the operation; no partial output.
- States: IDLE, CHECK, NORM_L, ROUND, DONE; state_leds one-hot IDLE=0001, CHECK/NORM_L=0010, ROUND=0100, DONE=1000.
- IDLE: in_ready=1; on in_valid&&in_ready register sign/exp/mant, guard=0 -> CHECK.
- CHECK (1 cycle):
  - mant==0 -> result {sign,0,0}, zero flag -> DONE.
  - in_exp==0 (mant!=0) -> flush {sign,0,0}, underflow -> DONE.
  - in_exp==255 -> {sign,255,0}, overflow -> DONE.
  - mant[MAN_W+1]=1 -> mant>>=1, guard=shifted-out bit, exp+1; exp becomes 255 -> infinity, overflow -> DONE; else -> ROUND.
  - mant[MAN_W]=1 -> ROUND; else -> NORM_L.
- NORM_L: per cycle mant<<=1, exp-1; stop into ROUND when mant[MAN_W]=1. If exp==1 and still unnormalized -> flush to signed zero, underflow -> DONE. No subnormals produced.
- ROUND (1 cycle): single guard bit, no sticky, so guard=1 is an exact tie: increment iff guard&&mant[0]. Increment carrying into bit MAN_W+1 -> shift right 1, exp+1; exp reaching 255 -> infinity, overflow. Pack {sign, exp, mant[MAN_W-1:0]} -> DONE.
- DONE: out_valid=1; out_result/out_flags stable while out_ready=0. On out_ready -> IDLE, out_valid=0 next cycle. out_result holds last value until next DONE.
- Latency acceptance edge -> out_valid: 3 cycles when no left shift; +1 per left shift (max 23 -> 26); special cases (zero/exp 0/exp 255/overflow in CHECK) 2 cycles.
- in_valid while busy ignored (in_ready=0); upstream holds data.

Optional Feature:
FP_NORM_FAST_EN: defined -> NORM_L takes exactly one cycle: leading-zero count on mant, single barrel shift by min(lzc, exp-1), underflow if lzc >= exp. Max latency 4. Undefined -> iterative 1-bit-per-cycle shifting as above. Results are bit-identical in both builds.

Decomposition:
- Package fp_pkg: EXP_W, MAN_W, BIAS, EXP_MAX, state enum type, flags struct {overflow, underflow, zero}.
- Sub-module fp_lzc (leading-zero counter, MAN_W+1 input), instantiated only under FP_NORM_FAST_EN.

Test Plan:
- sign0, exp 127, mant 25'h1000000 (1+1) -> 0x40000000, flags 000, out_valid 3 cycles after accept.
- exp 127, mant 25'h0400000 -> one left shift -> 0x3F000000, latency 4 (fast build 4).
- exp 127, mant 25'h1FFFFFF -> right shift, guard=1, lsb=1, round carry -> 0x40800000, flags 000.
- sign1, mant 0 -> 0x80000000, zero flag; exp 254, mant 25'h1000000 -> 0x7F800000, overflow flag.
- exp 1, mant 25'h0400000 -> 0x00000000, underflow flag.
- out_ready low 5 cycles in DONE -> out_result stable, in_ready=0; assert reset mid NORM_L -> next cycle IDLE, out_valid=0, out_result=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, state encoding and flag layout for the single-precision
// post-adder normalize/round/pack stage (fp_norm_pack).
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int RES_W = 1 + EXP_W + MAN_W;
    localparam int LZC_W = $clog2(MAN_W + 2);

    // All-ones exponent (2**EXP_W-1) marks infinity; equals 2*BIAS+1.
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);
    localparam logic [EXP_W-1:0] EXP_SAT = EXP_MAX - 1'b1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_NORM_L,
        ST_ROUND,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic zero;
    } flags_t;

    localparam flags_t FL_NONE  = flags_t'(3'b000);
    localparam flags_t FL_ZERO  = flags_t'(3'b001);
    localparam flags_t FL_UNDER = flags_t'(3'b010);
    localparam flags_t FL_OVER  = flags_t'(3'b100);

    function automatic logic [RES_W-1:0] pack_fp(input logic             s,
                                                 input logic [EXP_W-1:0] e,
                                                 input logic [MAN_W-1:0] f);
        return {s, e, f};
    endfunction

    function automatic logic [3:0] leds_of(input state_e s);
        logic [3:0] leds;
        case (s)
            ST_IDLE:             leds = 4'b0001;
            ST_CHECK, ST_NORM_L: leds = 4'b0010;
            ST_ROUND:            leds = 4'b0100;
            ST_DONE:             leds = 4'b1000;
            default:             leds = 4'b0001;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the hidden bit and fraction (MAN_W+1 bits).
// Only instantiated when FP_NORM_FAST_EN is defined.
module fp_lzc
    import fp_pkg::*;
(
    input  logic [MAN_W:0]   val_i,
    output logic [LZC_W-1:0] lzc_o
);

    always_comb begin
        lzc_o = LZC_W'(MAN_W + 1);
        // Ascending scan: the highest set bit is the last one to write.
        for (int i = 0; i <= MAN_W; i++) begin
            if (val_i[i]) begin
                lzc_o = LZC_W'(MAN_W - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_pack.sv
// Normalize, round-to-nearest-even and pack the raw add/sub mantissa sum into
// an IEEE-754 single. FP_NORM_FAST_EN selects a one-cycle barrel-shift NORM_L.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | in_ready high, waiting for an upstream result
// ST_CHECK  | special cases, carry right-shift with guard capture
// ST_NORM_L | left-normalize until the hidden bit is set (or underflow)
// ST_ROUND  | nearest-even on the single guard bit, pack the result
// ST_DONE   | out_valid high, result held until out_ready
module fp_norm_pack
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic [MAN_W+1:0]   in_mant,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_result,
    output logic [2:0]         out_flags,
    output logic [3:0]         state_leds
);

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [MAN_W+1:0]   mant_q, mant_d;
    logic               guard_q, guard_d;
    logic [RES_W-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;

    logic               round_up;
    logic [MAN_W+1:0]   rounded;

    // Guard is the only bit below the LSB, so guard=1 is always an exact tie.
    assign round_up = guard_q & mant_q[0];
    assign rounded  = mant_q + {{(MAN_W+1){1'b0}}, round_up};

`ifdef FP_NORM_FAST_EN
    logic [LZC_W-1:0]   lzc;

    fp_lzc u_lzc (
        .val_i (mant_q[MAN_W:0]),
        .lzc_o (lzc)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= FL_NONE;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    guard_d = 1'b0;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (mant_q == '0) begin
                    result_d = pack_fp(sign_q, '0, '0);
                    flags_d  = FL_ZERO;
                    state_d  = ST_DONE;
                end else if (exp_q == '0) begin
                    result_d = pack_fp(sign_q, '0, '0);
                    flags_d  = FL_UNDER;
                    state_d  = ST_DONE;
                end else if (exp_q == EXP_MAX) begin
                    result_d = pack_fp(sign_q, EXP_MAX, '0);
                    flags_d  = FL_OVER;
                    state_d  = ST_DONE;
                end else if (mant_q[MAN_W+1]) begin
                    mant_d  = mant_q >> 1;
                    guard_d = mant_q[0];
                    exp_d   = exp_q + 1'b1;
                    if (exp_q == EXP_SAT) begin
                        result_d = pack_fp(sign_q, EXP_MAX, '0);
                        flags_d  = FL_OVER;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_ROUND;
                    end
                end else if (mant_q[MAN_W]) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_NORM_L;
                end
            end

            ST_NORM_L: begin
`ifdef FP_NORM_FAST_EN
                // Reaching exponent 0 would need a subnormal; flush instead.
                if (EXP_W'(lzc) >= exp_q) begin
                    result_d = pack_fp(sign_q, '0, '0);
                    flags_d  = FL_UNDER;
                    state_d  = ST_DONE;
                end else begin
                    mant_d  = mant_q << lzc;
                    exp_d   = exp_q - EXP_W'(lzc);
                    state_d = ST_ROUND;
                end
`else
                if (exp_q == EXP_ONE) begin
                    result_d = pack_fp(sign_q, '0, '0);
                    flags_d  = FL_UNDER;
                    state_d  = ST_DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 1'b1;
                    if (mant_q[MAN_W-1]) begin
                        state_d = ST_ROUND;
                    end
                end
`endif
            end

            ST_ROUND: begin
                flags_d = FL_NONE;
                state_d = ST_DONE;
                if (rounded[MAN_W+1]) begin
                    if (exp_q == EXP_SAT) begin
                        result_d = pack_fp(sign_q, EXP_MAX, '0);
                        flags_d  = FL_OVER;
                    end else begin
                        result_d = pack_fp(sign_q, exp_q + 1'b1, rounded[MAN_W:1]);
                    end
                end else begin
                    result_d = pack_fp(sign_q, exp_q, rounded[MAN_W-1:0]);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign state_leds = leds_of(state_q);

endmodule

// File: tb/tb_fp_norm_pack.sv
// Scoreboard bench for fp_norm_pack: directed vectors push expectations, a
// monitor pops and compares whenever out_valid is presented.
module tb_fp_norm_pack;
    import fp_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic [EXP_W-1:0]   in_exp;
    logic [MAN_W+1:0]   in_mant;
    logic               out_valid;
    logic               out_ready;
    logic [RES_W-1:0]   out_result;
    logic [2:0]         out_flags;
    logic [3:0]         state_leds;

    fp_norm_pack dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .state_leds (state_leds)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat_i;
        int          lat_f;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        int          acc;
        int          hold;
        int          id;
    } exp_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];
    exp_t sb [$];
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 32'h40000000, 3'b000,  3,  3, 0};
        vecs[1]  = '{1'b0, 8'd127, 25'h0400000, 32'h3F000000, 3'b000,  4,  4, 0};
        vecs[2]  = '{1'b0, 8'd127, 25'h1FFFFFF, 32'h40800000, 3'b000,  3,  3, 0};
        vecs[3]  = '{1'b1, 8'd127, 25'h0000000, 32'h80000000, 3'b001,  2,  2, 0};
        vecs[4]  = '{1'b0, 8'd254, 25'h1000000, 32'h7F800000, 3'b100,  2,  2, 0};
        vecs[5]  = '{1'b0, 8'd1,   25'h0400000, 32'h00000000, 3'b010,  3,  3, 0};
        vecs[6]  = '{1'b0, 8'd127, 25'h1000001, 32'h40000000, 3'b000,  3,  3, 0};
        vecs[7]  = '{1'b0, 8'd127, 25'h1000003, 32'h40000002, 3'b000,  3,  3, 0};
        vecs[8]  = '{1'b1, 8'd127, 25'h0C00000, 32'hBFC00000, 3'b000,  3,  3, 5};
        vecs[9]  = '{1'b1, 8'd0,   25'h0800000, 32'h80000000, 3'b010,  2,  2, 0};
        vecs[10] = '{1'b0, 8'd255, 25'h0800000, 32'h7F800000, 3'b100,  2,  2, 0};
        vecs[11] = '{1'b0, 8'd253, 25'h1FFFFFF, 32'h7F800000, 3'b100,  3,  3, 0};
        vecs[12] = '{1'b0, 8'd127, 25'h0000001, 32'h34000000, 3'b000, 26,  4, 0};
        vecs[13] = '{1'b0, 8'd24,  25'h0000001, 32'h00800000, 3'b000, 26,  4, 0};
        vecs[14] = '{1'b0, 8'd23,  25'h0000001, 32'h00000000, 3'b010, 25,  3, 0};
        vecs[15] = '{1'b1, 8'd0,   25'h0000000, 32'h80000000, 3'b001,  2,  2, 0};
    end

    // Monitor: compares each presented result, then exercises back-pressure.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                mon_busy = 1'b1;
                if (sb.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v%0d_result", e.id), out_result, e.res);
                    check($sformatf("v%0d_flags", e.id), {29'd0, out_flags}, {29'd0, e.fl});
                    check($sformatf("v%0d_latency", e.id), cyc - e.acc, e.lat);
                    check($sformatf("v%0d_leds_done", e.id), {28'd0, state_leds}, 32'h8);
                    check($sformatf("v%0d_in_ready_busy", e.id), {31'd0, in_ready}, 32'd0);
                    for (int i = 0; i < e.hold; i++) begin
                        out_ready = 1'b0;
                        @(negedge clk);
                        check($sformatf("v%0d_hold_result", e.id), out_result, e.res);
                        check($sformatf("v%0d_hold_valid", e.id), {31'd0, out_valid}, 32'd1);
                        check($sformatf("v%0d_hold_in_ready", e.id), {31'd0, in_ready}, 32'd0);
                    end
                    out_ready = 1'b1;
                    @(negedge clk);
                    check($sformatf("v%0d_valid_drop", e.id), {31'd0, out_valid}, 32'd0);
                    check($sformatf("v%0d_result_held", e.id), out_result, e.res);
                end
                mon_busy = 1'b0;
            end
        end
    end

    task automatic send(input int id);
        exp_t e;
        int   n;
        @(negedge clk);
        in_sign  = vecs[id].s;
        in_exp   = vecs[id].e;
        in_mant  = vecs[id].m;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now($sformatf("v%0d_accept_timeout", id));
        end else begin
            e.res  = vecs[id].res;
            e.fl   = vecs[id].fl;
`ifdef FP_NORM_FAST_EN
            e.lat  = vecs[id].lat_f;
`else
            e.lat  = vecs[id].lat_i;
`endif
            e.acc  = cyc;
            e.hold = vecs[id].hold;
            e.id   = id;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(sb.size() == 0 && !mon_busy && in_ready && !out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("drain_timeout");
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},   32'd1);
        check("rst_out_valid", {31'd0, out_valid},  32'd0);
        check("rst_result",    out_result,          32'd0);
        check("rst_flags",     {29'd0, out_flags},  32'd0);
        check("rst_leds",      {28'd0, state_leds}, 32'h1);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) send(i);
        drain();

        // Abandon a long left-normalization by asserting reset inside NORM_L.
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_mant  = 25'h0000001;
        in_valid = 1'b1;
        check("mid_pre_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("mid_check_leds", {28'd0, state_leds}, 32'h2);
        @(negedge clk);
        check("mid_norm_leds", {28'd0, state_leds}, 32'h2);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready",  {31'd0, in_ready},   32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid},  32'd0);
        check("mid_rst_result",    out_result,          32'd0);
        check("mid_rst_flags",     {29'd0, out_flags},  32'd0);
        check("mid_rst_leds",      {28'd0, state_leds}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        end
        check("post_rst_leds", {28'd0, state_leds}, 32'h1);
        check("post_rst_result", out_result, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
